binary_adder_accum: RTL and testbench
=====================================

# binary_adder_accum

Sequential stage directly downstream of the 4-bit binary adder. Consumes one adder result per handshake beat, treating `{COUT, SUM}` as a 5-bit unsigned value 0..31. Accumulates a fixed number of beats into a wide running total, then presents the total with a sticky overflow flag on a valid/ready output port. Lets the combinational adder be exercised as a multi-beat datapath under clocked control.

## Interface
- `ACC_W`, default 16: accumulator and output total width; legal range ≥ 6.
- `BEATS`, default 4: adder results summed per output; legal range ≥ 1.
- `CLK`  in  1  sole clock, rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `IN_VALID`  in  1  `SUM`/`COUT` carry a valid adder result.
- `IN_READY`  out  1  block accepts a beat this cycle.
- `SUM`  in  4  adder sum bits.
- `COUT`  in  1  adder carry-out.
- `OUT_VALID`  out  1  `OUT_TOTAL`/`OUT_OVF` valid.
- `OUT_READY`  in  1  consumer accepts the result.
- `OUT_TOTAL`  out  ACC_W  accumulated total, modulo 2^ACC_W.
- `OUT_OVF`  out  1  total exceeded 2^ACC_W−1 during this group.
- `BEAT_CNT`  out  $clog2(BEATS+1)  beats accepted in the current group.

## Operation
- **Beat accept:** `IN_VALID && IN_READY` on a rising edge.
- **Beat value:** `{COUT, SUM}` zero-extended to ACC_W.
- **FSM states:**
  - ACCUM (reset state): `IN_READY=1`, `OUT_VALID=0`. Each accepted beat adds its value to `acc` and increments `BEAT_CNT`.
  - ACCUM → DONE on the edge that accepts beat number BEATS.
  - DONE: `IN_READY=0`, `OUT_VALID=1`. `OUT_TOTAL`, `OUT_OVF` and `BEAT_CNT=BEATS` are held stable.
  - DONE → ACCUM on the edge with `OUT_READY=1`. On that edge `acc`, `BEAT_CNT` and `OUT_OVF` clear to 0.
- **Arithmetic:**
  - The add is computed ACC_W+1 bits wide; `acc` keeps the low ACC_W bits (wrap-around).
  - `OUT_OVF` is set when bit ACC_W of any add in the group is 1, and stays set until the group is consumed.
- **Input gaps:** `IN_VALID=0` in ACCUM leaves all state unchanged.
- **SUM/COUT are don't-care** when `IN_VALID=0` or while in DONE.
- **Reset:** `RST=1` forces ACCUM, `acc=0`, `BEAT_CNT=0`, `OUT_OVF=0`. It overrides any simultaneous beat or output handshake. A partial group is discarded.
- **X handling:** no X on any output after the first reset edge.

## Timing
- **Reset values:** `IN_READY=1`, `OUT_VALID=0`, `OUT_TOTAL=0`, `OUT_OVF=0`, `BEAT_CNT=0`.
- **`IN_READY` and `OUT_VALID`** are decoded combinationally from the registered state only; neither depends on `IN_VALID` or `OUT_READY`.
- **`OUT_TOTAL` and `OUT_OVF`** are registered: visible the cycle after the final beat's edge.
- **Latency:** final beat edge → `OUT_VALID=1` is 1 cycle.
- **Throughput:**
  - Minimum group period is BEATS + 1 cycles.
  - With `OUT_READY` held high, `OUT_VALID` is high for exactly 1 cycle.
  - The next beat is accepted on the edge after the release.
- **Ordering:** no beat is accepted on the same edge as the output handshake.
- **Backpressure:** `OUT_READY=0` holds DONE indefinitely with outputs stable.
- **BEATS=1:** every accepted beat produces a result.

## Structure
- Package `adder_pkg`:
  - state enum `accum_state_t {ACCUM, DONE}`;
  - localparam `BEAT_VAL_W = 5`;
  - function returning the `BEAT_CNT` width for a given BEATS.
- One sub-module is natural: `adder_beat_counter`.
  - Ports: `CLK`, `RST`, `inc`, `clr`, `count`, `last`.
  - Parameterised by BEATS.
  - `last` is asserted when the increment reaches BEATS.
- Accumulator register, overflow flag and FSM live in the top module.
- Bench instantiates `binary_adder_4bit` feeding this block to check the pair end-to-end.

## Test plan
- **Reset values:** assert reset → all outputs at reset values, `IN_READY=1`.
- **Defaults, end-to-end:** via the adder, A=0011, B=0101 for 4 consecutive beats → `OUT_TOTAL=32`, `OUT_OVF=0`, `OUT_VALID=1` the cycle after the 4th beat.
- **Carry beats with gaps:** beats A=1111, B=0001 (value 16) interleaved with `IN_VALID=0` gap cycles → total 64 after 4 accepted beats; `BEAT_CNT` steps 0,1,2,3,4 only on accepts.
- **Overflow (ACC_W=6, BEATS=4):** four beats of value 31 (A=1111, B=1111 gives 30; drive `SUM=1111`, `COUT=1` directly) → `OUT_TOTAL=60` (124 mod 64), `OUT_OVF=1`; the next group of four 1s → total 4, `OUT_OVF=0`.
- **Backpressure:** `OUT_READY=0` for 5 cycles in DONE, with `IN_VALID=1` throughout → outputs stable, `IN_READY=0`, no beat absorbed; `OUT_READY=1` → clears, the next beat is counted as beat 1.
- **Reset mid-group:** `RST` after 2 beats (total 16) → `acc=0`, `BEAT_CNT=0`; four subsequent beats of 8 → total 32.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and helpers for the adder accumulator stage.
package adder_pkg;

    typedef enum logic {
        ACCUM,
        DONE
    } accum_state_t;

    localparam int BEAT_VAL_W = 5;

    // Width needed to hold a beat count from 0 up to and including beats.
    function automatic int cnt_width(input int beats);
        return $clog2(beats + 1);
    endfunction

endpackage

// File: rtl/adder_beat_counter.sv
// Counts accepted beats within a group; last flags the beat that completes it.
module adder_beat_counter
    import adder_pkg::*;
#(
    parameter  int BEATS = 4,
    localparam int CW    = cnt_width(BEATS)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          last
);

    assign last = inc && (count == CW'(BEATS - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/binary_adder_4bit.sv
// Combinational 4-bit binary adder with carry-in and carry-out.
module binary_adder_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       CIN,
    output logic [3:0] SUM,
    output logic       COUT
);

    assign {COUT, SUM} = {1'b0, A} + {1'b0, B} + {4'b0000, CIN};

endmodule

// File: rtl/binary_adder_accum.sv
// Sums BEATS adder results {COUT,SUM} into a wrap-around total with a sticky
// overflow flag, then offers the total on a valid/ready output port.
//
//   state | meaning
//   ------+------------------------------------------------
//   ACCUM | accepting beats, adding each into acc
//   DONE  | group complete, total held until OUT_READY
module binary_adder_accum
    import adder_pkg::*;
#(
    parameter  int ACC_W = 16,
    parameter  int BEATS = 4,
    localparam int CW    = cnt_width(BEATS)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [3:0]       SUM,
    input  logic             COUT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [ACC_W-1:0] OUT_TOTAL,
    output logic             OUT_OVF,
    output logic [CW-1:0]    BEAT_CNT
);

    accum_state_t            state, state_nxt;
    logic [ACC_W-1:0]        acc;
    logic                    ovf;
    logic [BEAT_VAL_W-1:0]   beat_val;
    logic [ACC_W:0]          add_w;
    logic                    beat_acc;
    logic                    out_hs;
    logic                    last_beat;

    assign beat_val = {COUT, SUM};
    assign add_w    = {1'b0, acc} + {{(ACC_W + 1 - BEAT_VAL_W){1'b0}}, beat_val};
    assign beat_acc = IN_VALID && IN_READY;
    assign out_hs   = OUT_VALID && OUT_READY;

    adder_beat_counter #(.BEATS(BEATS)) u_beat_counter (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (beat_acc),
        .clr   (out_hs),
        .count (BEAT_CNT),
        .last  (last_beat)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
        case (state)
            ACCUM: begin
                IN_READY = 1'b1;
                if (beat_acc && last_beat) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                OUT_VALID = 1'b1;
                if (OUT_READY) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // Overflow is sticky across the group: any carry out of the top bit sets it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (out_hs) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (beat_acc) begin
            acc <= add_w[ACC_W-1:0];
            if (add_w[ACC_W]) begin
                ovf <= 1'b1;
            end
        end
    end

    assign OUT_TOTAL = acc;
    assign OUT_OVF   = ovf;

endmodule

// File: tb/tb_binary_adder_accum.sv
// Directed and randomized checks of binary_adder_accum, end-to-end with the adder.
module tb_binary_adder_accum;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [3:0] ad_a = '0, ad_b = '0;
    logic       ad_cin = 1'b0;
    logic [3:0] ad_sum;
    logic       ad_cout;

    logic        v0 = 1'b0, ordy0 = 1'b0, r0, ov0, ovf0;
    logic [15:0] tot0;
    logic [2:0]  cnt0;

    logic [3:0]  sum1 = '0;
    logic        cout1 = 1'b0;
    logic        v1 = 1'b0, ordy1 = 1'b0, r1, ov1, ovf1;
    logic [5:0]  tot1;
    logic [2:0]  cnt1;

    logic        v2 = 1'b0, ordy2 = 1'b0, r2, ov2, ovf2;
    logic [5:0]  tot2;
    logic [0:0]  cnt2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    binary_adder_4bit u_adder (
        .A(ad_a), .B(ad_b), .CIN(ad_cin), .SUM(ad_sum), .COUT(ad_cout)
    );

    binary_adder_accum #(.ACC_W(16), .BEATS(4)) dut0 (
        .CLK(clk), .RST(rst), .IN_VALID(v0), .IN_READY(r0), .SUM(ad_sum), .COUT(ad_cout),
        .OUT_VALID(ov0), .OUT_READY(ordy0), .OUT_TOTAL(tot0), .OUT_OVF(ovf0), .BEAT_CNT(cnt0)
    );

    binary_adder_accum #(.ACC_W(6), .BEATS(4)) dut1 (
        .CLK(clk), .RST(rst), .IN_VALID(v1), .IN_READY(r1), .SUM(sum1), .COUT(cout1),
        .OUT_VALID(ov1), .OUT_READY(ordy1), .OUT_TOTAL(tot1), .OUT_OVF(ovf1), .BEAT_CNT(cnt1)
    );

    binary_adder_accum #(.ACC_W(6), .BEATS(1)) dut2 (
        .CLK(clk), .RST(rst), .IN_VALID(v2), .IN_READY(r2), .SUM(sum1), .COUT(cout1),
        .OUT_VALID(ov2), .OUT_READY(ordy2), .OUT_TOTAL(tot2), .OUT_OVF(ovf2), .BEAT_CNT(cnt2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int m_tot0, m_cnt0, m_tot1, m_cnt1, a, b, c, val;
        bit m_done0, m_done1;

        tick();
        tick();
        chk("rst_in_ready", 32'(r0), 1);
        chk("rst_out_valid", 32'(ov0), 0);
        chk("rst_total", 32'(tot0), 0);
        chk("rst_ovf", 32'(ovf0), 0);
        chk("rst_cnt", 32'(cnt0), 0);
        chk("rst_in_ready1", 32'(r1), 1);
        chk("rst_in_ready2", 32'(r2), 1);
        rst = 1'b0;

        // 3 + 5 = 8 per beat, four beats
        ad_a = 4'd3; ad_b = 4'd5; ad_cin = 1'b0; v0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("e2e_cnt", 32'(cnt0), 32'(k));
            chk("e2e_not_valid", 32'(ov0), 0);
            tick();
        end
        v0 = 1'b0;
        chk("e2e_valid", 32'(ov0), 1);
        chk("e2e_total", 32'(tot0), 32);
        chk("e2e_ovf", 32'(ovf0), 0);
        chk("e2e_ready_low", 32'(r0), 0);
        ordy0 = 1'b1;
        tick();
        ordy0 = 1'b0;
        chk("e2e_release_valid", 32'(ov0), 0);
        chk("e2e_release_total", 32'(tot0), 0);

        // 15 + 1 = 16 with carry, gaps between beats
        ad_a = 4'd15; ad_b = 4'd1;
        for (int k = 0; k < 4; k++) begin
            v0 = 1'b0;
            tick();
            chk("gap_hold_cnt", 32'(cnt0), 32'(k));
            v0 = 1'b1;
            tick();
            chk("gap_step_cnt", 32'(cnt0), 32'(k + 1));
        end
        chk("gap_total", 32'(tot0), 64);
        chk("gap_valid", 32'(ov0), 1);
        chk("gap_ovf", 32'(ovf0), 0);

        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_valid", 32'(ov0), 1);
            chk("bp_ready", 32'(r0), 0);
            chk("bp_total", 32'(tot0), 64);
            chk("bp_cnt", 32'(cnt0), 4);
        end
        ad_a = 4'd3; ad_b = 4'd5;
        ordy0 = 1'b1;
        tick();
        ordy0 = 1'b0;
        chk("bp_rel_valid", 32'(ov0), 0);
        chk("bp_rel_cnt", 32'(cnt0), 0);
        chk("bp_rel_total", 32'(tot0), 0);
        chk("bp_rel_ready", 32'(r0), 1);
        tick();
        chk("bp_next_cnt", 32'(cnt0), 1);
        chk("bp_next_total", 32'(tot0), 8);
        tick();
        chk("mid_cnt", 32'(cnt0), 2);
        chk("mid_total", 32'(tot0), 16);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_cnt", 32'(cnt0), 0);
        chk("mid_rst_total", 32'(tot0), 0);
        chk("mid_rst_ready", 32'(r0), 1);
        for (int k = 0; k < 4; k++) tick();
        v0 = 1'b0;
        chk("mid_after_total", 32'(tot0), 32);
        chk("mid_after_valid", 32'(ov0), 1);
        ordy0 = 1'b1;
        tick();
        ordy0 = 1'b0;

        // Overflow in the narrow accumulator: 4 x 31 = 124, wraps to 60
        sum1 = 4'd15; cout1 = 1'b1; v1 = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        chk("ovf_total", 32'(tot1), 60);
        chk("ovf_flag", 32'(ovf1), 1);
        chk("ovf_valid", 32'(ov1), 1);
        ordy1 = 1'b1;
        tick();
        ordy1 = 1'b0;
        chk("ovf_clr_flag", 32'(ovf1), 0);
        chk("ovf_clr_total", 32'(tot1), 0);
        sum1 = 4'd1; cout1 = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        v1 = 1'b0;
        chk("ovf_next_total", 32'(tot1), 4);
        chk("ovf_next_flag", 32'(ovf1), 0);
        ordy1 = 1'b1;
        tick();
        ordy1 = 1'b0;

        // BEATS=1: every accepted beat is a full group
        v2 = 1'b1; ordy2 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            val = $urandom_range(0, 31);
            {cout1, sum1} = 5'(val);
            tick();
            chk("b1_valid", 32'(ov2), 1);
            chk("b1_total", 32'(tot2), 32'(val));
            chk("b1_cnt", 32'(cnt2), 1);
            tick();
            chk("b1_release", 32'(ov2), 0);
            chk("b1_total_clr", 32'(tot2), 0);
        end
        v2 = 1'b0; ordy2 = 1'b0;

        // Random traffic against a group-level reference model
        m_tot0 = 0; m_cnt0 = 0; m_done0 = 0;
        m_tot1 = 0; m_cnt1 = 0; m_done1 = 0;
        for (int i = 0; i < 120; i++) begin
            a = $urandom_range(0, 15);
            b = $urandom_range(0, 15);
            c = $urandom_range(0, 1);
            ad_a = 4'(a); ad_b = 4'(b); ad_cin = c[0];
            v0 = ($urandom_range(0, 3) != 0);
            ordy0 = ($urandom_range(0, 1) != 0);
            val = $urandom_range(0, 31);
            {cout1, sum1} = 5'(val);
            v1 = ($urandom_range(0, 3) != 0);
            ordy1 = ($urandom_range(0, 1) != 0);

            if (m_done0) begin
                if (ordy0) begin m_done0 = 0; m_tot0 = 0; m_cnt0 = 0; end
            end else if (v0) begin
                m_tot0 += a + b + c; m_cnt0++;
                if (m_cnt0 == 4) m_done0 = 1;
            end
            if (m_done1) begin
                if (ordy1) begin m_done1 = 0; m_tot1 = 0; m_cnt1 = 0; end
            end else if (v1) begin
                m_tot1 += val; m_cnt1++;
                if (m_cnt1 == 4) m_done1 = 1;
            end

            tick();
            chk("rnd0_valid", 32'(ov0), 32'(m_done0));
            chk("rnd0_ready", 32'(r0), 32'(!m_done0));
            chk("rnd0_cnt", 32'(cnt0), 32'(m_cnt0));
            chk("rnd0_total", 32'(tot0), 32'(m_tot0 % 65536));
            chk("rnd0_ovf", 32'(ovf0), 32'(m_tot0 > 65535));
            chk("rnd1_valid", 32'(ov1), 32'(m_done1));
            chk("rnd1_cnt", 32'(cnt1), 32'(m_cnt1));
            chk("rnd1_total", 32'(tot1), 32'(m_tot1 % 64));
            chk("rnd1_ovf", 32'(ovf1), 32'(m_tot1 > 63));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
